// File: rtl/ext_bus_responder.sv
// Slave end of the multiplexed 8051 external bus (ALE/PSEN/RD/WR).
// Serves code/xdata reads onto P0 and turns writes into req/ack memory cycles.
module ext_bus_responder #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ale,
  input  logic        psen_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  p0_in,
  input  logic [7:0]  p2_in,
  output logic [7:0]  p0_out,
  output logic        p0_oe,
  output logic [15:0] mem_addr,
  output logic        mem_space,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        late,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_DRIVE, RD_DISCARD, WR_CAPT, WR_REQ
  } state_t;

  state_t      state, state_d;
  logic        s_ale, s_psen_n, s_rd_n, s_wr_n;
  logic        q_psen_n, q_rd_n, q_wr_n;
  logic [7:0]  s_p0, s_p2, a_lo;
  logic        err_q, oe_q, oe_d;
  logic [7:0]  cnt, cnt_d;
  logic [7:0]  p0_out_d, wdata_d;
  logic [15:0] addr_d;
  logic        space_d, rd_d, wr_d, late_d, err_d;

  logic        psen_fall, rd_fall, wr_fall, wr_rise;
  logic [1:0]  active;
  logic        proto, req_any, timeout, strb_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_ale    <= 1'b0;
      s_psen_n <= 1'b1;
      s_rd_n   <= 1'b1;
      s_wr_n   <= 1'b1;
      q_psen_n <= 1'b1;
      q_rd_n   <= 1'b1;
      q_wr_n   <= 1'b1;
      s_p0     <= 8'h00;
      s_p2     <= 8'h00;
      a_lo     <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      s_ale    <= ale;
      s_psen_n <= psen_n;
      s_rd_n   <= rd_n;
      s_wr_n   <= wr_n;
      q_psen_n <= s_psen_n;
      q_rd_n   <= s_rd_n;
      q_wr_n   <= s_wr_n;
      s_p0     <= p0_in;
      s_p2     <= p2_in;
      err_q    <= proto;
      if (s_ale) a_lo <= s_p0;
    end
  end

  assign psen_fall = q_psen_n & ~s_psen_n;
  assign rd_fall   = q_rd_n & ~s_rd_n;
  assign wr_fall   = q_wr_n & ~s_wr_n;
  assign wr_rise   = ~q_wr_n & s_wr_n;
  assign active    = {1'b0, ~s_psen_n} + {1'b0, ~s_rd_n}
                   + {1'b0, ~s_wr_n};
  assign proto     = active > 2'd1;
  assign req_any   = mem_rd_req | mem_wr_req;
  assign timeout   = req_any & ~mem_ack
                   & (cnt >= 8'(WAIT_MAX - 1));
  assign strb_n    = mem_space ? s_rd_n : s_psen_n;
  assign p0_oe     = oe_q & ~s_ale;

  always_comb begin
    state_d  = state;
    oe_d     = oe_q;
    p0_out_d = p0_out;
    addr_d   = mem_addr;
    space_d  = mem_space;
    rd_d     = mem_rd_req;
    wr_d     = mem_wr_req;
    wdata_d  = mem_wdata;
    late_d   = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt;
    if (req_any && cnt < 8'(WAIT_MAX)) cnt_d = cnt + 8'd1;
    if (proto) begin
      // A request already on the memory port runs to its ack.
      err_d   = ~err_q | timeout;
      oe_d    = 1'b0;
      state_d = IDLE;
      if ((req_any && mem_ack) || timeout) begin
        rd_d = 1'b0;
        wr_d = 1'b0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (req_any) begin
            if (mem_ack || timeout) begin
              rd_d  = 1'b0;
              wr_d  = 1'b0;
              err_d = timeout;
            end
          end else if (psen_fall || rd_fall) begin
            rd_d    = 1'b1;
            addr_d  = {s_p2, a_lo};
            space_d = rd_fall;
            cnt_d   = 8'd0;
            state_d = RD_REQ;
          end else if (wr_fall) begin
            addr_d  = {s_p2, a_lo};
            space_d = 1'b1;
            wdata_d = s_p0;
            state_d = WR_CAPT;
          end
        end
        RD_REQ: begin
          if (mem_ack) begin
            rd_d = 1'b0;
            if (!strb_n && !s_ale) begin
              p0_out_d = mem_rdata;
              oe_d     = 1'b1;
              state_d  = RD_DRIVE;
            end else begin
              late_d  = strb_n;
              state_d = IDLE;
            end
          end else if (strb_n) begin
            late_d  = 1'b1;
            state_d = RD_DISCARD;
          end else if (timeout) begin
            err_d   = 1'b1;
            rd_d    = 1'b0;
            state_d = IDLE;
          end
        end
        RD_DRIVE: begin
          if (strb_n || s_ale) begin
            oe_d    = 1'b0;
            state_d = IDLE;
          end
        end
        RD_DISCARD: begin
          if (mem_ack || timeout) begin
            err_d   = timeout;
            rd_d    = 1'b0;
            state_d = IDLE;
          end
        end
        WR_CAPT: begin
          if (!s_wr_n) wdata_d = s_p0;
          if (wr_rise) begin
            wr_d    = 1'b1;
            space_d = 1'b1;
            cnt_d   = 8'd0;
            state_d = WR_REQ;
          end
        end
        WR_REQ: begin
          if (mem_ack || timeout) begin
            err_d   = timeout;
            wr_d    = 1'b0;
            state_d = IDLE;
          end else if (psen_fall || rd_fall || wr_fall) begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      oe_q       <= 1'b0;
      p0_out     <= 8'h00;
      mem_addr   <= 16'h0000;
      mem_space  <= 1'b0;
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      mem_wdata  <= 8'h00;
      late       <= 1'b0;
      bus_err    <= 1'b0;
      cnt        <= 8'd0;
    end else begin
      state      <= state_d;
      oe_q       <= oe_d;
      p0_out     <= p0_out_d;
      mem_addr   <= addr_d;
      mem_space  <= space_d;
      mem_rd_req <= rd_d;
      mem_wr_req <= wr_d;
      mem_wdata  <= wdata_d;
      late       <= late_d;
      bus_err    <= err_d;
      cnt        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ext_bus_responder.sv
// Bench for ext_bus_responder: bus cycles with random timing, expected
// behaviour derived per cycle from strobe length and ack delay.
module tb_ext_bus_responder;

  localparam int W = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ale = 1'b0;
  logic        psen_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [7:0]  p0_in = 8'h00;
  logic [7:0]  p2_in = 8'h00;
  logic [7:0]  p0_out;
  logic        p0_oe;
  logic [15:0] mem_addr;
  logic        mem_space;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic        late;
  logic        bus_err;

  int vecs = 0;
  int errs = 0;

  ext_bus_responder #(.WAIT_MAX(W)) dut (
    .clk(clk), .reset(reset), .ale(ale), .psen_n(psen_n),
    .rd_n(rd_n), .wr_n(wr_n), .p0_in(p0_in), .p2_in(p2_in),
    .p0_out(p0_out), .p0_oe(p0_oe), .mem_addr(mem_addr),
    .mem_space(mem_space), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .late(late),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic addr_phase(input logic [15:0] a);
    @(posedge clk); #1;
    ale = 1'b1; p0_in = a[7:0]; p2_in = 8'($urandom);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ale = 1'b0; p2_in = a[15:8]; p0_in = 8'($urandom);
  endtask

  task automatic test_idle(input int n);
    logic [4:0] got;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_rdata = 8'($urandom);
      @(negedge clk);
      got = {mem_rd_req, mem_wr_req, p0_oe, late, bus_err};
      vecs++;
      if (got !== 5'b0) begin
        errs++;
        $display("FAIL idle ctl got %b want 00000", got);
      end
    end
  endtask

  task automatic test_reset();
    logic [44:0] got;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mem_rdata = 8'($urandom);
      p0_in = 8'($urandom);
      p2_in = 8'($urandom);
      if (i == 2) reset = 1'b0;
      @(negedge clk);
      got = {p0_out, p0_oe, mem_addr, mem_space, mem_rd_req,
             mem_wr_req, mem_wdata, late, bus_err, 8'h00};
      vecs++;
      if (got !== 45'd0) begin
        errs++;
        $display("FAIL reset i=%0d outs got %h want 0", i, got);
      end
    end
  endtask

  // Read cycle: strobe pin low for cycles 0..L-1, ack during cycle 2+D.
  task automatic test_read(input bit code, input logic [15:0] a,
                           input int L, input int D, input bit ack_en,
                           input logic [7:0] rdat);
    bit served, is_late;
    int req_end, tend;
    logic [4:0] got, exp;
    served  = ack_en && (L >= D + 2);
    is_late = ack_en && (L <= D + 1);
    req_end = ack_en ? 2 + D : W + 1;
    tend    = ((L + 1 > req_end) ? L + 1 : req_end) + 4;
    if (!ack_en) tend = W + 6 + L;
    addr_phase(a);
    for (int t = 0; t <= tend; t++) begin
      @(posedge clk); #1;
      if (code) psen_n = (t < L) ? 1'b0 : 1'b1;
      else rd_n = (t < L) ? 1'b0 : 1'b1;
      mem_ack   = ack_en && (t == 2 + D);
      mem_rdata = (t == 2 + D) ? rdat : 8'($urandom);
      p0_in     = 8'($urandom);
      @(negedge clk);
      exp[4] = (t >= 2) && (t <= req_end);
      exp[3] = 1'b0;
      exp[2] = served && (t >= 3 + D) && (t <= L + 1);
      exp[1] = is_late && (t == L + 2);
      exp[0] = !ack_en && (t == W + 2);
      got = {mem_rd_req, mem_wr_req, p0_oe, late, bus_err};
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL read t=%0d ctl got %b want %b", t, got, exp);
      end
      if (exp[4]) begin
        vecs++;
        if ({mem_space, mem_addr} !== {~code, a}) begin
          errs++;
          $display("FAIL read addr got %b/%h want %b/%h",
                   mem_space, mem_addr, ~code, a);
        end
      end
      if (exp[2]) begin
        vecs++;
        if (p0_out !== rdat) begin
          errs++;
          $display("FAIL read data got %h want %h", p0_out, rdat);
        end
      end
    end
    mem_ack = 1'b0;
  endtask

  // Write cycle: wr_n low for cycles 0..L-1, last data wd, ack D after req.
  task automatic test_write(input logic [15:0] a, input int L,
                            input int D, input logic [7:0] wd);
    int rs, re;
    logic [4:0] got, exp;
    rs = L + 2;
    re = L + 2 + D;
    addr_phase(a);
    for (int t = 0; t <= re + 3; t++) begin
      @(posedge clk); #1;
      wr_n      = (t < L) ? 1'b0 : 1'b1;
      p0_in     = (t == L - 1) ? wd : 8'($urandom);
      mem_ack   = (t == re);
      mem_rdata = 8'($urandom);
      @(negedge clk);
      exp = {1'b0, (t >= rs) && (t <= re), 3'b000};
      got = {mem_rd_req, mem_wr_req, p0_oe, late, bus_err};
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL write t=%0d ctl got %b want %b", t, got, exp);
      end
      if (exp[3]) begin
        vecs++;
        if ({mem_space, mem_addr, mem_wdata} !== {1'b1, a, wd}) begin
          errs++;
          $display("FAIL write bus got %b/%h/%h want 1/%h/%h",
                   mem_space, mem_addr, mem_wdata, a, wd);
        end
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_proto();
    logic [4:0] got, exp;
    addr_phase(16'($urandom));
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      rd_n = (t < 3) ? 1'b0 : 1'b1;
      wr_n = (t < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      exp = {4'b0000, t == 2};
      got = {mem_rd_req, mem_wr_req, p0_oe, late, bus_err};
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL proto t=%0d ctl got %b want %b", t, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rdat;
    logic [27:0] got;
    rdat = 8'($urandom);
    addr_phase(16'hBEEF);
    for (int t = 0; t <= 7; t++) begin
      @(posedge clk); #1;
      rd_n      = (t < 6) ? 1'b0 : 1'b1;
      reset     = (t == 6);
      mem_ack   = (t == 4);
      mem_rdata = (t == 4) ? rdat : 8'($urandom);
      @(negedge clk);
      if (t == 6) begin
        vecs++;
        if ({p0_oe, p0_out} !== {1'b1, rdat}) begin
          errs++;
          $display("FAIL rstmid drive got %b/%h want 1/%h",
                   p0_oe, p0_out, rdat);
        end
      end
      if (t == 7) begin
        got = {p0_oe, mem_rd_req, mem_wr_req, late, bus_err,
               mem_space, mem_addr, 6'd0};
        vecs++;
        if (got !== 28'd0) begin
          errs++;
          $display("FAIL rstmid outs got %h want 0", got);
        end
      end
    end
    test_idle(3);
    test_read(1'b1, 16'($urandom), 6, 2, 1'b1, 8'($urandom));
  endtask

  initial begin
    int k, L, D;
    test_reset();
    test_idle(2);
    test_read(1'b1, 16'h1234, 8, 3, 1'b1, 8'hA5);
    test_idle(2);
    test_write(16'h00F0, 2, 1, 8'h5A);
    test_idle(2);
    test_read(1'b0, 16'h4321, 3, 5, 1'b1, 8'h77);
    test_idle(2);
    test_read(1'b1, 16'h0F0F, W + 2, 0, 1'b0, 8'h00);
    test_idle(2);
    test_proto();
    test_idle(2);
    test_reset_mid_read();
    test_idle(2);
    for (int n = 0; n < 14; n++) begin
      k = $urandom_range(0, 3);
      case (k)
        0: begin
          D = $urandom_range(0, 8);
          L = D + 2 + $urandom_range(0, 4);
          test_read(1'($urandom), 16'($urandom), L, D, 1'b1,
                    8'($urandom));
        end
        1: begin
          D = $urandom_range(3, 10);
          L = $urandom_range(1, D);
          test_read(1'($urandom), 16'($urandom), L, D, 1'b1,
                    8'($urandom));
        end
        2: begin
          L = $urandom_range(1, 5);
          D = $urandom_range(0, 8);
          test_write(16'($urandom), L, D, 8'($urandom));
        end
        default: begin
          L = W + 1 + $urandom_range(0, 4);
          test_read(1'($urandom), 16'($urandom), L, 0, 1'b0, 8'h00);
        end
      endcase
      test_idle(2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
